// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM / flash bus controllers.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    TURN
  } state_t;

  localparam int unsigned WAIT_W = 4;

  // Index of the device that carries byte lane `lane` when each device is chip_dw bits wide.
  function automatic int unsigned lane_to_chip(input int unsigned lane,
                                               input int unsigned chip_dw);
    return lane / (chip_dw / 8);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable wait-state down-counter; done is high while the count is zero.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              en,
  output logic              done
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave for a bank of asynchronous SRAMs with byte lanes and wait states.
// Define SRAM_TURNAROUND_EN to insert a bus turnaround cycle on a write that follows a read.
module sram_wb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int CHIPS   = 2,
  parameter  int CHIP_DW = 16,
  parameter  int AW      = 18,
  parameter  int RD_WAIT = 1,
  parameter  int WR_WAIT = 1,
  localparam int DW      = CHIPS * CHIP_DW,
  localparam int SW      = DW / 8
) (
  input  logic             clk_50mhz,
  input  logic             reset_n,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [SW-1:0]    wb_sel_i,
  input  logic [DW-1:0]    wb_dat_i,
  output logic [DW-1:0]    wb_dat_o,
  output logic             wb_ack_o,
  output logic [AW-1:0]    sram_addr_o,
  output logic [DW-1:0]    sram_dat_o,
  input  logic [DW-1:0]    sram_dat_i,
  output logic [SW-1:0]    sram_dq_oe_o,
  output logic [CHIPS-1:0] sram_cen_o,
  output logic [SW-1:0]    sram_ben_o,
  output logic             sram_oen_o,
  output logic             sram_wen_o
);

  state_t state, state_next;

  logic [AW-1:0] req_adr;
  logic [SW-1:0] req_sel;
  logic          req_we;
  logic [DW-1:0] req_dat;
  logic          aborted;

  logic          accept;
  logic          ack_next;
  logic          cnt_done;

  logic [AW-1:0]    cur_adr;
  logic [SW-1:0]    cur_sel;
  logic             cur_we;
  logic [DW-1:0]    cur_dat;
  logic [CHIPS-1:0] chip_en_n;
  logic [DW-1:0]    rd_mask;

  logic [AW-1:0]    addr_next;
  logic [DW-1:0]    dat_next;
  logic [CHIPS-1:0] cen_next;
  logic [SW-1:0]    ben_next;
  logic [SW-1:0]    dq_oe_next;
  logic             oen_next;
  logic             wen_next;

`ifdef SRAM_TURNAROUND_EN
  logic last_rd;
`endif

  // A pending ack blocks acceptance so a master still holding stb is not served twice.
  assign accept = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;

  sram_wait_cnt u_wait_cnt (
    .clk      (clk_50mhz),
    .rst_n    (reset_n),
    .load     (state == SETUP),
    .load_val (req_we ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT)),
    .en       (state == ACCESS),
    .done     (cnt_done)
  );

  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (wb_sel_i == '0) begin
            ack_next = 1'b1;
`ifdef SRAM_TURNAROUND_EN
          end else if (wb_we_i && last_rd) begin
            state_next = TURN;
`endif
          end else begin
            state_next = SETUP;
          end
        end
      end
      TURN:   state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (cnt_done) begin
          state_next = HOLD;
          ack_next   = wb_cyc_i && !aborted;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are computed for the upcoming state and registered; in IDLE the request is still
  // on the bus, afterwards the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      cur_adr = wb_adr_i;
      cur_sel = wb_sel_i;
      cur_we  = wb_we_i;
      cur_dat = wb_dat_i;
    end else begin
      cur_adr = req_adr;
      cur_sel = req_sel;
      cur_we  = req_we;
      cur_dat = req_dat;
    end
  end

  always_comb begin
    chip_en_n = '1;
    for (int unsigned c = 0; c < CHIPS; c++) begin
      for (int unsigned l = 0; l < SW; l++) begin
        if (cur_sel[l] && (lane_to_chip(l, CHIP_DW) == c)) begin
          chip_en_n[c] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_mask = '0;
    for (int unsigned l = 0; l < SW; l++) begin
      rd_mask[8*l +: 8] = {8{req_sel[l]}};
    end
  end

  always_comb begin
    addr_next  = sram_addr_o;
    dat_next   = sram_dat_o;
    cen_next   = '1;
    ben_next   = '1;
    dq_oe_next = '0;
    oen_next   = 1'b1;
    wen_next   = 1'b1;
    if (state_next inside {SETUP, ACCESS, HOLD}) begin
      addr_next = cur_adr;
      cen_next  = chip_en_n;
      ben_next  = ~cur_sel;
      if (cur_we) begin
        dq_oe_next = cur_sel;
        dat_next   = cur_dat;
        wen_next   = (state_next != ACCESS);
      end else begin
        oen_next = (state_next == HOLD);
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      req_adr <= '0;
      req_sel <= '0;
      req_we  <= 1'b0;
      req_dat <= '0;
      aborted <= 1'b0;
    end else if (accept) begin
      req_adr <= wb_adr_i;
      req_sel <= wb_sel_i;
      req_we  <= wb_we_i;
      req_dat <= wb_dat_i;
      aborted <= 1'b0;
    end else if ((state inside {TURN, SETUP, ACCESS}) && !wb_cyc_i) begin
      aborted <= 1'b1;
    end
  end

`ifdef SRAM_TURNAROUND_EN
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      last_rd <= 1'b0;
    end else if (accept && (wb_sel_i != '0)) begin
      last_rd <= !wb_we_i;
    end
  end
`endif

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr_o  <= '0;
      sram_dat_o   <= '0;
      sram_cen_o   <= '1;
      sram_ben_o   <= '1;
      sram_dq_oe_o <= '0;
      sram_oen_o   <= 1'b1;
      sram_wen_o   <= 1'b1;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
    end else begin
      sram_addr_o  <= addr_next;
      sram_dat_o   <= dat_next;
      sram_cen_o   <= cen_next;
      sram_ben_o   <= ben_next;
      sram_dq_oe_o <= dq_oe_next;
      sram_oen_o   <= oen_next;
      sram_wen_o   <= wen_next;
      wb_ack_o     <= ack_next;
      if ((state == ACCESS) && cnt_done && !req_we) begin
        wb_dat_o <= sram_dat_i & rd_mask;
      end
    end
  end

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Self-checking bench for sram_wb_ctrl: vector table plus scoreboard, with a behavioural SRAM.
module tb_sram_wb_ctrl;

  localparam int CHIPS   = 2;
  localparam int CHIP_DW = 16;
  localparam int AW      = 18;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [17:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat;
  logic [31:0] rd_dat;
  logic        ack;
  logic [17:0] sram_addr;
  logic [31:0] pad_wdat;
  logic [31:0] pad_rdat;
  logic [3:0]  dq_oe;
  logic [1:0]  cen;
  logic [3:0]  ben;
  logic        oen, wen;

  always #10 clk = ~clk;

  sram_wb_ctrl #(
    .CHIPS   (CHIPS),
    .CHIP_DW (CHIP_DW),
    .AW      (AW),
    .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT)
  ) dut (
    .clk_50mhz    (clk),
    .reset_n      (reset_n),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_we_i      (wb_we),
    .wb_adr_i     (wb_adr),
    .wb_sel_i     (wb_sel),
    .wb_dat_i     (wb_dat),
    .wb_dat_o     (rd_dat),
    .wb_ack_o     (ack),
    .sram_addr_o  (sram_addr),
    .sram_dat_o   (pad_wdat),
    .sram_dat_i   (pad_rdat),
    .sram_dq_oe_o (dq_oe),
    .sram_cen_o   (cen),
    .sram_ben_o   (ben),
    .sram_oen_o   (oen),
    .sram_wen_o   (wen)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SRAM: reads drive selected lanes, unselected lanes carry junk.
  logic [31:0] mem [256];

  always_comb begin
    pad_rdat = '0;
    for (int l = 0; l < 4; l++) begin
      pad_rdat[8*l +: 8] = (!oen && !cen[l/2] && !ben[l]) ? mem[sram_addr[7:0]][8*l +: 8]
                                                          : 8'hEE;
    end
  end

  // Bus monitor, sampled on the falling edge; writes commit at the end of the WE# pulse.
  logic       mon_en   = 1'b1;
  logic       prev_wen = 1'b1;
  logic [1:0] prev_cen = 2'b11;
  int         wen_run  = 0;
  int         pulse_cnt = 0;
  int         cen_fall = 0;
  int         oe_clash = 0;
  logic [1:0] wr_cen;
  logic [3:0] wr_ben;
  logic [3:0] wr_dqoe;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (!oen && (dq_oe != 4'b0)) oe_clash++;
      for (int c = 0; c < 2; c++) begin
        if (prev_cen[c] && !cen[c]) cen_fall++;
      end
      if (!wen) begin
        wen_run++;
        wr_cen  = cen;
        wr_ben  = ben;
        wr_dqoe = dq_oe;
      end else if (!prev_wen) begin
        if (mon_en) check("we_pulse_len", 32'(wen_run), 32'(WR_WAIT + 1));
        pulse_cnt++;
        wen_run = 0;
        for (int l = 0; l < 4; l++) begin
          if (!ben[l] && !cen[l/2] && dq_oe[l]) mem[sram_addr[7:0]][8*l +: 8] = pad_wdat[8*l +: 8];
        end
      end
      prev_wen = wen;
      prev_cen = cen;
    end
  end

  typedef struct {
    logic [31:0] dat;
    int          lat;
    logic        chk_dat;
  } exp_t;

  exp_t sb[$];

`ifdef SRAM_TURNAROUND_EN
  logic model_last_rd = 1'b0;
`endif

  function automatic int exp_lat(input logic we, input logic [3:0] sel);
    if (sel == 4'b0) return 1;
    if (!we) return 3 + RD_WAIT;
`ifdef SRAM_TURNAROUND_EN
    if (model_last_rd) return 4 + WR_WAIT;
`endif
    return 3 + WR_WAIT;
  endfunction

  task automatic do_xfer(input logic we, input logic [17:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [31:0] exp_dat);
    exp_t e;
    exp_t got_e;
    int   lat;
    bit   got;
    e.dat     = exp_dat;
    e.lat     = exp_lat(we, sel);
    e.chk_dat = !we && (sel != 4'b0);
`ifdef SRAM_TURNAROUND_EN
    if (sel != 4'b0) model_last_rd = !we;
`endif
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = we;
    wb_adr = adr;
    wb_sel = sel;
    wb_dat = dat;
    sb.push_back(e);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) got = 1'b1;
    end
    got_e = sb.pop_front();
    check("ack_seen", 32'(got), 32'(1));
    if (got) begin
      check("latency", 32'(lat), 32'(got_e.lat));
      if (got_e.chk_dat) check("rdata", rd_dat, got_e.dat);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    @(posedge clk);
    #1;
    check("ack_one_cycle", 32'(ack), 32'(0));
  endtask

  typedef struct {
    logic        we;
    logic [17:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[14];

  task automatic wait_wen_low(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!wen) found = 1'b1;
    end
  endtask

  initial begin
    int  pulses0;
    int  falls0;
    int  acks;
    bit  found;

    vecs[0]  = '{1'b0, 18'h010, 4'hF,    32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 18'h020, 4'b0100, 32'h00AB0000, 32'h0};
    vecs[2]  = '{1'b0, 18'h020, 4'hF,    32'h0,        32'hC0AB0020};
    vecs[3]  = '{1'b1, 18'h030, 4'b0011, 32'h12345678, 32'h0};
    vecs[4]  = '{1'b0, 18'h030, 4'b0011, 32'h0,        32'h00005678};
    vecs[5]  = '{1'b0, 18'h030, 4'hF,    32'h0,        32'hC0DE5678};
    vecs[6]  = '{1'b1, 18'h040, 4'hF,    32'hCAFEF00D, 32'h0};
    vecs[7]  = '{1'b0, 18'h040, 4'b1000, 32'h0,        32'hCA000000};
    vecs[8]  = '{1'b0, 18'h040, 4'hF,    32'h0,        32'hCAFEF00D};
    vecs[9]  = '{1'b1, 18'h041, 4'b1001, 32'hAABBCCDD, 32'h0};
    vecs[10] = '{1'b0, 18'h041, 4'hF,    32'h0,        32'hAADE00DD};
    vecs[11] = '{1'b1, 18'h050, 4'b0000, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, 18'h050, 4'hF,    32'h0,        32'hC0DE0050};
    vecs[13] = '{1'b0, 18'h051, 4'b0000, 32'h0,        32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[8'h10] = 32'hDEADBEEF;

    reset_n = 1'b0;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
    wb_adr  = '0;
    wb_sel  = '0;
    wb_dat  = '0;
    #35;
    check("rst_cen",   32'(cen),       32'h3);
    check("rst_ben",   32'(ben),       32'hF);
    check("rst_oen",   32'(oen),       32'h1);
    check("rst_wen",   32'(wen),       32'h1);
    check("rst_dq_oe", 32'(dq_oe),     32'h0);
    check("rst_ack",   32'(ack),       32'h0);
    check("rst_addr",  32'(sram_addr), 32'h0);
    check("rst_pad_dat", pad_wdat,     32'h0);
    check("rst_wb_dat",  rd_dat,       32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      pulses0 = pulse_cnt;
      falls0  = cen_fall;
      do_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].exp_dat);
      check("we_pulse_count", 32'(pulse_cnt - pulses0),
            32'((vecs[i].we && vecs[i].sel != 4'b0) ? 1 : 0));
      if (vecs[i].sel == 4'b0) check("sel0_no_cen", 32'(cen_fall - falls0), 32'h0);
      if (i == 1) begin
        check("bytewr_cen",   32'(wr_cen),  32'h1);
        check("bytewr_ben",   32'(wr_ben),  32'hB);
        check("bytewr_dq_oe", 32'(wr_dqoe), 32'h4);
        check("bytewr_mem",   mem[8'h20],   32'hC0AB0020);
      end
    end

    // cyc dropped during the write pulse: pulse completes, no ack.
    pulses0 = pulse_cnt;
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b1;
    wb_adr = 18'h060;
    wb_sel = 4'hF;
    wb_dat = 32'h11223344;
    wait_wen_low(found);
    check("abort_reached_access", 32'(found), 32'h1);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    check("abort_no_ack",      32'(acks),                32'h0);
    check("abort_full_pulse",  32'(pulse_cnt - pulses0), 32'h1);
    check("abort_mem",         mem[8'h60],               32'h11223344);
`ifdef SRAM_TURNAROUND_EN
    model_last_rd = 1'b0;
`endif
    do_xfer(1'b0, 18'h060, 4'hF, 32'h0, 32'h11223344);

    check("no_dq_oe_while_oen", 32'(oe_clash), 32'h0);

    // Asynchronous reset in the middle of a write pulse.
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b1;
    wb_adr = 18'h070;
    wb_sel = 4'hF;
    wb_dat = 32'h55AA55AA;
    wait_wen_low(found);
    check("rst_mid_wr_reached", 32'(found), 32'h1);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wen",   32'(wen),   32'h1);
    check("rst_mid_cen",   32'(cen),   32'h3);
    check("rst_mid_ben",   32'(ben),   32'hF);
    check("rst_mid_dq_oe", 32'(dq_oe), 32'h0);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
